// File: rtl/key_pkg.sv
// Shared encodings for the key front end: per-key mode values,
// channel FSM states and a saturating 16-bit increment.
package key_pkg;

   typedef logic [1:0] kmode_t;

   localparam kmode_t KM_PLAIN     = 2'b00;
   localparam kmode_t KM_SHORTLONG = 2'b01;
   localparam kmode_t KM_REPEAT    = 2'b10;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_HELD,
      ST_LONG_DONE
   } kstate_e;

   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

endpackage

// File: rtl/key_channel.sv
// One key: 2-FF synchroniser, tick-based debounce and press/hold FSM.
// Ports: clk, rst (sync, active-low), tick_i, key_i, mode_i; level_o
// plus single-cycle registered pulses press/release/short/long/rpt.
module key_channel
   import key_pkg::*;
#(
   parameter int ACTIVE_HIGH   = 1,
   parameter int DB_TICKS      = 20,
   parameter int LONG_TICKS    = 1000,
   parameter int REPEAT_DELAY  = 500,
   parameter int REPEAT_PERIOD = 100
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       tick_i,
   input  logic       key_i,
   input  logic [1:0] mode_i,
   output logic       level_o,
   output logic       press_o,
   output logic       release_o,
   output logic       short_o,
   output logic       long_o,
   output logic       rpt_o
);

   localparam int DBW = $clog2(DB_TICKS + 1);
   localparam logic [DBW-1:0] DB_LAST = DBW'(DB_TICKS - 1);
   localparam logic [15:0] LONG_C  = 16'(LONG_TICKS);
   localparam logic [15:0] RD_C    = 16'(REPEAT_DELAY);
   localparam logic [15:0] RP_LAST = 16'(REPEAT_PERIOD - 1);
   localparam logic IDLE_LVL = (ACTIVE_HIGH == 0);

   logic [1:0]     sync_q;
   logic           raw;
   logic [DBW-1:0] db_q, db_d;
   logic           level_q, level_d;
   logic           rise, fall;
   kstate_e        state_q, state_d;
   logic [15:0]    hold_q, hold_d, hold_inc;
   logic [15:0]    rep_q, rep_d;
   kmode_t         mode_q, mode_d;
   logic           press_q, press_d;
   logic           rel_q, rel_d;
   logic           short_q, short_d;
   logic           long_q, long_d;
   logic           rpt_q, rpt_d;

   assign raw = sync_q[1] ^ IDLE_LVL;

   // Debounce: level flips on the DB_TICKS-th consecutive differing tick.
   always_comb begin
      db_d    = db_q;
      level_d = level_q;
      if (tick_i) begin
         if (raw != level_q) begin
            if (db_q == DB_LAST) begin
               db_d    = '0;
               level_d = ~level_q;
            end else begin
               db_d = db_q + 1'b1;
            end
         end else begin
            db_d = '0;
         end
      end
   end

   // Edges of the next level, so pulses land with the level change.
   assign rise     = level_d & ~level_q;
   assign fall     = ~level_d & level_q;
   assign hold_inc = sat_inc16(hold_q);

   always_ff @(posedge clk) begin
      if (!rst) begin
         sync_q  <= {2{IDLE_LVL}};
         db_q    <= '0;
         level_q <= 1'b0;
         state_q <= ST_IDLE;
         hold_q  <= '0;
         rep_q   <= '0;
         mode_q  <= KM_PLAIN;
         press_q <= 1'b0;
         rel_q   <= 1'b0;
         short_q <= 1'b0;
         long_q  <= 1'b0;
         rpt_q   <= 1'b0;
      end else begin
         sync_q  <= {sync_q[0], key_i};
         db_q    <= db_d;
         level_q <= level_d;
         state_q <= state_d;
         hold_q  <= hold_d;
         rep_q   <= rep_d;
         mode_q  <= mode_d;
         press_q <= press_d;
         rel_q   <= rel_d;
         short_q <= short_d;
         long_q  <= long_d;
         rpt_q   <= rpt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE: if (rise) state_d = ST_HELD;
         ST_HELD: begin
            if (fall)
               state_d = ST_IDLE;
            else if (tick_i && mode_q == KM_SHORTLONG && hold_inc == LONG_C)
               state_d = ST_LONG_DONE;
         end
         ST_LONG_DONE: if (fall) state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      hold_d  = hold_q;
      rep_d   = rep_q;
      mode_d  = mode_q;
      press_d = 1'b0;
      rel_d   = 1'b0;
      short_d = 1'b0;
      long_d  = 1'b0;
      rpt_d   = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (rise) begin
               press_d = 1'b1;
               hold_d  = '0;
               rep_d   = '0;
               mode_d  = mode_i;
            end
         end
         ST_HELD: begin
            if (fall) begin
               rel_d   = 1'b1;
               short_d = (mode_q == KM_SHORTLONG);
            end else if (tick_i) begin
               hold_d = hold_inc;
               long_d = (mode_q == KM_SHORTLONG) && (hold_inc == LONG_C);
               // rep_q counts ticks since the last repeat pulse.
               if (mode_q == KM_REPEAT) begin
                  if (hold_inc == RD_C) begin
                     rpt_d = 1'b1;
                     rep_d = '0;
                  end else if (hold_inc > RD_C) begin
                     if (rep_q == RP_LAST) begin
                        rpt_d = 1'b1;
                        rep_d = '0;
                     end else begin
                        rep_d = rep_q + 16'd1;
                     end
                  end
               end
            end
         end
         ST_LONG_DONE: begin
            if (fall) rel_d = 1'b1;
         end
         default: ;
      endcase
   end

   assign level_o   = level_q;
   assign press_o   = press_q;
   assign release_o = rel_q;
   assign short_o   = short_q;
   assign long_o    = long_q;
   assign rpt_o     = rpt_q;

endmodule

// File: rtl/key_frontend.sv
// N_KEYS-channel key conditioner: shared tick prescaler plus one
// key_channel per key. Ports: clk, rst (sync, active-low), key_in, mode;
// outputs level and single-cycle press/release/short/long/rpt pulses.
module key_frontend #(
   parameter int N_KEYS        = 5,
   parameter int ACTIVE_HIGH   = 1,
   parameter int TICK_DIV      = 100000,
   parameter int DB_TICKS      = 20,
   parameter int LONG_TICKS    = 1000,
   parameter int REPEAT_DELAY  = 500,
   parameter int REPEAT_PERIOD = 100
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [N_KEYS-1:0]     key_in,
   input  logic [2*N_KEYS-1:0]   mode,
   output logic [N_KEYS-1:0]     level,
   output logic [N_KEYS-1:0]     press_p,
   output logic [N_KEYS-1:0]     release_p,
   output logic [N_KEYS-1:0]     short_p,
   output logic [N_KEYS-1:0]     long_p,
   output logic [N_KEYS-1:0]     rpt_p
);

   localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [PW-1:0] P_LAST = PW'(TICK_DIV - 1);

   logic [PW-1:0] pre_q, pre_d;
   logic          tick;

   assign tick  = (pre_q == P_LAST);
   assign pre_d = tick ? '0 : pre_q + 1'b1;

   always_ff @(posedge clk) begin
      if (!rst) pre_q <= '0;
      else      pre_q <= pre_d;
   end

   for (genvar i = 0; i < N_KEYS; i++) begin : g_ch
      key_channel #(
         .ACTIVE_HIGH  (ACTIVE_HIGH),
         .DB_TICKS     (DB_TICKS),
         .LONG_TICKS   (LONG_TICKS),
         .REPEAT_DELAY (REPEAT_DELAY),
         .REPEAT_PERIOD(REPEAT_PERIOD)
      ) u_ch (
         .clk      (clk),
         .rst      (rst),
         .tick_i   (tick),
         .key_i    (key_in[i]),
         .mode_i   (mode[2*i+1 -: 2]),
         .level_o  (level[i]),
         .press_o  (press_p[i]),
         .release_o(release_p[i]),
         .short_o  (short_p[i]),
         .long_o   (long_p[i]),
         .rpt_o    (rpt_p[i])
      );
   end

endmodule

// File: tb/tb_key_frontend.sv
// Directed bench for key_frontend with small tick/debounce constants.
// A negedge monitor logs pulse counts and cycle stamps per key.
module tb_key_frontend;

   logic       clk = 1'b0;
   logic       rst;
   logic [4:0] key_in;
   logic [9:0] mode;
   logic [4:0] level, press_p, release_p, short_p, long_p, rpt_p;

   int checks = 0;
   int failures = 0;

   key_frontend #(
      .N_KEYS(5), .ACTIVE_HIGH(1), .TICK_DIV(4), .DB_TICKS(3),
      .LONG_TICKS(10), .REPEAT_DELAY(6), .REPEAT_PERIOD(2)
   ) dut (
      .clk(clk), .rst(rst), .key_in(key_in), .mode(mode),
      .level(level), .press_p(press_p), .release_p(release_p),
      .short_p(short_p), .long_p(long_p), .rpt_p(rpt_p)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   int prs_n[5] = '{default: 0};
   int rel_n[5] = '{default: 0};
   int sht_n[5] = '{default: 0};
   int lng_n[5] = '{default: 0};
   int rpt_n[5] = '{default: 0};
   int prs_at[5] = '{default: 0};
   int rel_at[5] = '{default: 0};
   int sht_at[5] = '{default: 0};
   int lng_at[5] = '{default: 0};
   int rpt_hist[5][8];

   always @(negedge clk) begin
      cyc <= cyc + 1;
      for (int k = 0; k < 5; k++) begin
         if (press_p[k] === 1'b1) begin
            prs_n[k] <= prs_n[k] + 1;
            prs_at[k] <= cyc;
         end
         if (release_p[k] === 1'b1) begin
            rel_n[k] <= rel_n[k] + 1;
            rel_at[k] <= cyc;
         end
         if (short_p[k] === 1'b1) begin
            sht_n[k] <= sht_n[k] + 1;
            sht_at[k] <= cyc;
         end
         if (long_p[k] === 1'b1) begin
            lng_n[k] <= lng_n[k] + 1;
            lng_at[k] <= cyc;
         end
         if (rpt_p[k] === 1'b1) begin
            rpt_hist[k][rpt_n[k] % 8] <= cyc;
            rpt_n[k] <= rpt_n[k] + 1;
         end
      end
   end

   function automatic int total_pulses();
      int s = 0;
      for (int k = 0; k < 5; k++)
         s += prs_n[k] + rel_n[k] + sht_n[k] + lng_n[k] + rpt_n[k];
      return s;
   endfunction

   task automatic wait_press(input int k, input int base, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 80; i++) begin
         @(negedge clk); #1;
         if (prs_n[k] != base) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b0;
      key_in = 5'b00001;
      mode = '0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk); #1;
         checks++;
         if ({level, press_p, release_p, short_p, long_p, rpt_p} !== 30'd0) begin
            failures++;
            $display("FAIL reset_outputs got=%h want=0",
                     {level, press_p, release_p, short_p, long_p, rpt_p});
         end
      end
      rst = 1'b1;
      repeat (9) @(negedge clk);
      #1;
      checks++;
      if (level[0] !== 1'b0) begin
         failures++;
         $display("FAIL debounce_early level0=%b want=0", level[0]);
      end
      repeat (4) @(negedge clk);
      #1;
      checks++;
      if (level[0] !== 1'b1) begin
         failures++;
         $display("FAIL debounce_rise level0=%b want=1", level[0]);
      end
      checks++;
      if (prs_n[0] != 1) begin
         failures++;
         $display("FAIL press0_count got=%0d want=1", prs_n[0]);
      end
      key_in[0] = 1'b0;
      repeat (30) @(negedge clk);
      #1;
      checks++;
      if (rel_n[0] != 1 || level[0] !== 1'b0) begin
         failures++;
         $display("FAIL release0 count=%0d level=%b want=1,0", rel_n[0], level[0]);
      end
   endtask

   task automatic test_glitch();
      int base = total_pulses();
      int bad = 0;
      key_in[1] = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk); #1;
         if (level[1] !== 1'b0) bad++;
      end
      key_in[1] = 1'b0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk); #1;
         if (level[1] !== 1'b0) bad++;
      end
      checks++;
      if (bad != 0) begin
         failures++;
         $display("FAIL glitch_level high_cycles=%0d want=0", bad);
      end
      checks++;
      if (total_pulses() != base) begin
         failures++;
         $display("FAIL glitch_pulses got=%0d want=%0d", total_pulses(), base);
      end
   endtask

   task automatic test_short();
      int p0 = prs_n[1], r0 = rel_n[1], s0 = sht_n[1], l0 = lng_n[1];
      bit ok;
      mode[3:2] = 2'b01;
      key_in[1] = 1'b1;
      wait_press(1, p0, ok);
      checks++;
      if (!ok) begin
         failures++;
         $display("FAIL short_press timeout got=0 want=1");
      end
      repeat (20) @(negedge clk);
      key_in[1] = 1'b0;
      repeat (30) @(negedge clk);
      #1;
      checks++;
      if (rel_n[1] != r0 + 1 || sht_n[1] != s0 + 1) begin
         failures++;
         $display("FAIL short_counts rel=%0d short=%0d want=%0d,%0d",
                  rel_n[1], sht_n[1], r0 + 1, s0 + 1);
      end
      checks++;
      if (sht_at[1] != rel_at[1]) begin
         failures++;
         $display("FAIL short_same_cycle short_at=%0d rel_at=%0d", sht_at[1], rel_at[1]);
      end
      checks++;
      if (lng_n[1] != l0) begin
         failures++;
         $display("FAIL short_no_long got=%0d want=%0d", lng_n[1], l0);
      end
   endtask

   task automatic test_long();
      int p0 = prs_n[1], r0 = rel_n[1], s0 = sht_n[1], l0 = lng_n[1];
      bit ok;
      mode[3:2] = 2'b01;
      key_in[1] = 1'b1;
      wait_press(1, p0, ok);
      checks++;
      if (!ok) begin
         failures++;
         $display("FAIL long_press timeout got=0 want=1");
      end
      repeat (60) @(negedge clk);
      key_in[1] = 1'b0;
      repeat (30) @(negedge clk);
      #1;
      checks++;
      if (lng_n[1] != l0 + 1) begin
         failures++;
         $display("FAIL long_count got=%0d want=%0d", lng_n[1], l0 + 1);
      end
      checks++;
      if (lng_at[1] - prs_at[1] != 40) begin
         failures++;
         $display("FAIL long_time got=%0d want=40", lng_at[1] - prs_at[1]);
      end
      checks++;
      if (rel_n[1] != r0 + 1 || sht_n[1] != s0) begin
         failures++;
         $display("FAIL long_release rel=%0d short=%0d want=%0d,%0d",
                  rel_n[1], sht_n[1], r0 + 1, s0);
      end
   endtask

   // Key release in cycle press+41 makes level fall on hold tick 13.
   task automatic run_repeat(input int k, input string nm);
      int q0 = rpt_n[k], l0 = lng_n[k];
      int base;
      bit ok;
      key_in[k] = 1'b1;
      wait_press(k, prs_n[k], ok);
      checks++;
      if (!ok) begin
         failures++;
         $display("FAIL %s_press timeout got=0 want=1", nm);
      end
      base = prs_at[k];
      repeat (41) @(negedge clk);
      key_in[k] = 1'b0;
      repeat (40) @(negedge clk);
      #1;
      checks++;
      if (rpt_n[k] != q0 + 4) begin
         failures++;
         $display("FAIL %s_count got=%0d want=%0d", nm, rpt_n[k], q0 + 4);
      end
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (rpt_hist[k][(q0 + i) % 8] - base != 24 + 8 * i) begin
            failures++;
            $display("FAIL %s_time%0d got=%0d want=%0d", nm, i,
                     rpt_hist[k][(q0 + i) % 8] - base, 24 + 8 * i);
         end
      end
      checks++;
      if (rel_at[k] - base != 52 || lng_n[k] != l0) begin
         failures++;
         $display("FAIL %s_release rel_at=%0d long=%0d want=52,%0d", nm,
                  rel_at[k] - base, lng_n[k], l0);
      end
   endtask

   task automatic test_repeat();
      mode[5:4] = 2'b10;
      run_repeat(2, "repeat");
   endtask

   task automatic test_concurrent();
      int p4 = prs_n[4], r3 = rel_n[3], r4 = rel_n[4];
      int l3 = lng_n[3], q3 = rpt_n[3], s3 = sht_n[3];
      int o4 = sht_n[4] + lng_n[4] + rpt_n[4];
      bit ok;
      mode[7:6] = 2'b01;
      mode[9:8] = 2'b00;
      key_in[4:3] = 2'b11;
      wait_press(3, prs_n[3], ok);
      checks++;
      if (!ok || prs_n[4] != p4 + 1 || prs_at[3] != prs_at[4]) begin
         failures++;
         $display("FAIL conc_press ok=%0d at3=%0d at4=%0d", ok, prs_at[3], prs_at[4]);
      end
      repeat (8) @(negedge clk);
      mode[7:6] = 2'b10;
      repeat (48) @(negedge clk);
      key_in[4:3] = 2'b00;
      repeat (30) @(negedge clk);
      #1;
      checks++;
      if (lng_n[3] != l3 + 1 || lng_at[3] - prs_at[3] != 40) begin
         failures++;
         $display("FAIL latch_long count=%0d dt=%0d want=%0d,40",
                  lng_n[3], lng_at[3] - prs_at[3], l3 + 1);
      end
      checks++;
      if (rpt_n[3] != q3 || sht_n[3] != s3 || rel_n[3] != r3 + 1) begin
         failures++;
         $display("FAIL latch_other rpt=%0d short=%0d rel=%0d want=%0d,%0d,%0d",
                  rpt_n[3], sht_n[3], rel_n[3], q3, s3, r3 + 1);
      end
      checks++;
      if (rel_n[4] != r4 + 1 || sht_n[4] + lng_n[4] + rpt_n[4] != o4) begin
         failures++;
         $display("FAIL plain4 rel=%0d extra=%0d want=%0d,0", rel_n[4],
                  sht_n[4] + lng_n[4] + rpt_n[4] - o4, r4 + 1);
      end
      run_repeat(3, "newmode");
   endtask

   initial begin
      test_reset();
      test_glitch();
      test_short();
      test_long();
      test_repeat();
      test_concurrent();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
